// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam int MAX_DIGITS = 8;
  localparam int NIBBLE_W   = 4;

endpackage

// File: rtl/seg_scan_tick.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and flags the end of the slot and of its guard phase.
module seg_scan_tick #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end,
  output logic guard_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));

  // With no guard phase the FSM leaves GUARD as soon as it sees it.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign guard_end = 1'b1;
    end else begin : g_guard
      assign guard_end = (cnt == CNT_W'(GUARD_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode digit scanner with tear-free shadow registers and leading-zero blanking.
//   state | meaning
//   GUARD | all anodes off at slot start (anti-ghosting)
//   SHOW  | current digit's anode driven unless blanked
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  input  logic                         blank_lz,
  output logic [NIBBLE_W-1:0]          digit_data,
  output logic [NUM_DIGITS-1:0]        an,
  output logic                         dp,
  output logic                         frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic slot_end;
  logic guard_end;

  seg_scan_tick #(
    .SCAN_DIV     (SCAN_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_end  (slot_end),
    .guard_end (guard_end)
  );

  logic [NIBBLE_W*NUM_DIGITS-1:0] pend_val, shad_val, val_nx;
  logic [NUM_DIGITS-1:0]          pend_dp, shad_dp, dpr_nx;
  logic                           pend_blz, shad_blz, blz_nx;

  scan_state_e      state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;

  logic                  wrap;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank_nx;
  logic [NUM_DIGITS-1:0] an_nx;
  logic                  dp_nx;
  logic [NIBBLE_W-1:0]   nib_nx;

  // Outputs are registered, so everything is evaluated for the cycle after the edge.
  always_comb begin
    wrap     = slot_end && (idx == LAST_IDX);
    idx_nx   = idx;
    state_nx = state;
    if (slot_end) begin
      idx_nx   = wrap ? '0 : idx + IDX_W'(1);
      state_nx = (GUARD_CYCLES == 0) ? SHOW : GUARD;
    end else if (state == GUARD && guard_end) begin
      state_nx = SHOW;
    end

    val_nx = shad_val;
    dpr_nx = shad_dp;
    blz_nx = shad_blz;
    if (wrap) begin
      if (load) begin
        val_nx = value;
        dpr_nx = dp_in;
        blz_nx = blank_lz;
      end else begin
        val_nx = pend_val;
        dpr_nx = pend_dp;
        blz_nx = pend_blz;
      end
    end

    zero_run = 1'b1;
    blank_nx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (val_nx[NIBBLE_W*i +: NIBBLE_W] == '0);
      blank_nx[i] = blz_nx && zero_run && (i != 0);
    end

    an_nx  = '1;
    dp_nx  = 1'b1;
    nib_nx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nx == IDX_W'(i)) begin
        nib_nx = val_nx[NIBBLE_W*i +: NIBBLE_W];
        if (state_nx == SHOW && !blank_nx[i]) begin
          an_nx[i] = 1'b0;
          dp_nx    = ~dpr_nx[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= GUARD;
      idx         <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend_blz    <= 1'b0;
      shad_val    <= '0;
      shad_dp     <= '0;
      shad_blz    <= 1'b0;
      an          <= '1;
      dp          <= 1'b1;
      digit_data  <= '0;
      frame_start <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_blz <= blank_lz;
      end
      state       <= state_nx;
      idx         <= idx_nx;
      shad_val    <= val_nx;
      shad_dp     <= dpr_nx;
      shad_blz    <= blz_nx;
      an          <= an_nx;
      dp          <= dp_nx;
      digit_data  <= nib_nx;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-time model compared every cycle plus literal checks per scenario.
module tb_seg_scan_driver;
  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int GC    = 1;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    digit_data;
  logic [3:0]    an;
  logic          dp;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYCLES(GC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .digit_data  (digit_data),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t = cycles since reset release; shadow committed whenever t lands on a frame multiple.
  int          t = 0;
  logic [15:0] m_pend = '0, m_val = '0;
  logic [3:0]  m_pdp = '0, m_dp = '0;
  logic        m_pblz = 1'b0, m_blz = 1'b0;
  logic [3:0]  e_an, e_dd;
  logic        e_dp, e_fs;

  always @(posedge clk) begin
    int  di;
    bit  lit;
    if (!rst_n) begin
      t = 0; m_pend = '0; m_pdp = '0; m_pblz = 1'b0;
      m_val = '0; m_dp = '0; m_blz = 1'b0;
    end else begin
      t++;
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_pblz = blank_lz;
      end
      if (t % FRAME == 0) begin
        m_val = m_pend; m_dp = m_pdp; m_blz = m_pblz;
      end
    end
    di   = (t / SD) % ND;
    lit  = ((t % SD) >= GC) && !(m_blz && di != 0 && (m_val >> (4 * di)) == 16'h0);
    e_dd = 4'((m_val >> (4 * di)) & 16'hF);
    e_an = lit ? ~(4'b0001 << di) : 4'hF;
    e_dp = lit ? ~m_dp[di] : 1'b1;
    e_fs = (t != 0) && (t % FRAME == 0);
    #1;
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_dp", 32'(dp), 32'(e_dp));
    chk("model_digit_data", 32'(digit_data), 32'(e_dd));
    chk("model_frame_start", 32'(frame_start), 32'(e_fs));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic b);
    value = v; dp_in = d; blank_lz = b; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_fs();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 4 * FRAME && !got; k++) begin
      @(negedge clk);
      got = frame_start;
    end
    chk("frame_start_wait", 32'(got), 32'd1);
  endtask

  logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] scan_dd [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    int cnt_a, cnt_b;

    // reset held three cycles
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_dd", 32'(digit_data), 32'd0);
    end
    rst_n = 1'b1;
    chk("post_rst_c1_an", 32'(an), 32'hF);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("post_rst_show_an", 32'(an), 32'b1110);
    end
    step(1);
    chk("slot1_guard_an", 32'(an), 32'hF);

    // scan order
    pulse_load(16'h1234, 4'b0010, 1'b0);
    wait_fs();
    chk("scan_c0_dd", 32'(digit_data), 32'h4);
    chk("scan_c0_an", 32'(an), 32'hF);
    cnt_a = 0;
    for (int c = 1; c < FRAME; c++) begin
      step(1);
      if (frame_start) cnt_a++;
      if (c % SD == 1) begin
        chk("scan_an", 32'(an), 32'(scan_an[c / SD]));
        chk("scan_dd", 32'(digit_data), 32'(scan_dd[c / SD]));
        chk("scan_dp", 32'(dp), (c / SD == 1) ? 32'd0 : 32'd1);
      end
    end
    chk("scan_fs_within_frame", 32'(cnt_a), 32'd0);
    step(1);
    chk("scan_fs_period", 32'(frame_start), 32'd1);

    // leading-zero blanking
    pulse_load(16'h0050, 4'b1111, 1'b1);
    wait_fs();
    cnt_a = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) step(1);
      if (c >= 2 * SD && an != 4'hF) cnt_a++;
      if (c == 1) begin
        chk("lz_d0_dd", 32'(digit_data), 32'h0);
        chk("lz_d0_an", 32'(an), 32'b1110);
      end
      if (c == 5) begin
        chk("lz_d1_dd", 32'(digit_data), 32'h5);
        chk("lz_d1_an", 32'(an), 32'b1101);
        chk("lz_d1_dp", 32'(dp), 32'd0);
      end
      if (c == 9) chk("lz_d2_dp", 32'(dp), 32'd1);
    end
    chk("lz_upper_dark", 32'(cnt_a), 32'd0);

    pulse_load(16'h0000, 4'b0000, 1'b1);
    wait_fs();
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) step(1);
      if (an != 4'hF) cnt_a++;
      if (an == 4'b1110) cnt_b++;
    end
    chk("lz_zero_lit_cycles", 32'(cnt_a), 32'd3);
    chk("lz_zero_d0_cycles", 32'(cnt_b), 32'd3);

    // tear-free update
    pulse_load(16'hAAAA, 4'b0000, 1'b0);
    wait_fs();
    step(9);
    value = 16'hBBBB; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("tear_c10_dd", 32'(digit_data), 32'hA);
    step(3);
    chk("tear_c13_dd", 32'(digit_data), 32'hA);
    chk("tear_c13_an", 32'(an), 32'b0111);
    step(3);
    chk("tear_fs", 32'(frame_start), 32'd1);
    chk("tear_new_dd", 32'(digit_data), 32'hB);
    step(1);
    chk("tear_new_d0_an", 32'(an), 32'b1110);
    step(14);
    value = 16'hCCCC; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("coinc_fs", 32'(frame_start), 32'd1);
    chk("coinc_dd", 32'(digit_data), 32'hC);

    // reset mid-operation
    step(9);
    chk("midrst_pre_an", 32'(an), 32'b1011);
    rst_n = 1'b0; value = 16'hDDDD; load = 1'b1;
    step(1);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_dd", 32'(digit_data), 32'h0);
    chk("midrst_dp", 32'(dp), 32'd1);
    chk("midrst_fs", 32'(frame_start), 32'd0);
    rst_n = 1'b1; load = 1'b0;
    step(1);
    chk("midrst_rel_an", 32'(an), 32'b1110);
    chk("midrst_rel_dd", 32'(digit_data), 32'h0);
    wait_fs();
    step(1);
    chk("midrst_frame_an", 32'(an), 32'b1110);
    chk("midrst_frame_dd", 32'(digit_data), 32'h0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
